// File: rtl/alu_pkg.sv
// Shared constants, op encodings and issue-register payload for the ALU operand-fetch stage.
package alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned IMM_W    = 8;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_AND = 3'b001;
  localparam logic [OP_W-1:0] OP_OR  = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR = 3'b011;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
  } issue_t;

  // Any opcode with the top bit set is outside the ALU's repertoire.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two async read ports, one debug read port, one sync write port, r0 reads zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_a_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  input  logic [REG_AW-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_b_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Reset clears every entry and overrides any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = (rd_addr_a_i == '0) ? '0 : mem_q[rd_addr_a_i];
  assign rd_data_b_o = (rd_addr_b_i == '0) ? '0 : mem_q[rd_addr_b_i];
  assign dbg_data_o  = (dbg_addr_i  == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch/issue stage ahead of the ALU: operand read with forwarding, issue register,
// ALU writeback and Zero/illegal-op flags.
module alu_operand_fetch
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [OP_W-1:0]   Op,
  input  logic [REG_AW-1:0] Rd,
  input  logic [REG_AW-1:0] Rs1,
  input  logic [REG_AW-1:0] Rs2,
  input  logic              UseImm,
  input  logic [IMM_W-1:0]  Imm,
  input  logic              Stall,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   ALUControl,
  output logic              IssueValid,
  input  logic [DATA_W-1:0] WbResult,
  input  logic              WbZero,
  output logic              ZeroFlag,
  output logic              IllegalOp,
  input  logic [REG_AW-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  issue_t            issue_q, issue_d;
  logic              issue_valid_q, issue_valid_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] rf_a_c, rf_b_c;
  logic [DATA_W-1:0] op_a_c, op_b_c;
  logic              wb_en_c;

  assign wb_en_c = issue_valid_q && !Stall;

  alu_regfile u_regfile (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_a_i (Rs1),
    .rd_data_a_o (rf_a_c),
    .rd_addr_b_i (Rs2),
    .rd_data_b_o (rf_b_c),
    .dbg_addr_i  (DbgAddr),
    .dbg_data_o  (DbgData),
    .wr_en_i     (wb_en_c),
    .wr_addr_i   (issue_q.rd),
    .wr_data_i   (WbResult)
  );

  // Operand read: the op in the ALU has not written back yet, so take its result directly.
  always_comb begin
    op_a_c = rf_a_c;
    op_b_c = rf_b_c;
    if (Rs1 == '0) begin
      op_a_c = '0;
    end else if (issue_valid_q && (Rs1 == issue_q.rd)) begin
      op_a_c = WbResult;
    end
    if (UseImm) begin
      op_b_c = DATA_W'(Imm);
    end else if (Rs2 == '0) begin
      op_b_c = '0;
    end else if (issue_valid_q && (Rs2 == issue_q.rd)) begin
      op_b_c = WbResult;
    end
  end

  // Issue register and flags; everything holds while stalled.
  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    zero_d        = zero_q;
    illegal_d     = illegal_q;
    if (!Stall) begin
      issue_valid_d = 1'b0;
      if (issue_valid_q) begin
        zero_d = WbZero;
      end
      if (InstrValid) begin
        if (is_illegal_op(Op)) begin
          illegal_d = 1'b1;
        end else begin
          issue_d       = '{a: op_a_c, b: op_b_c, op: Op, rd: Rd};
          issue_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      zero_q        <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      zero_q        <= zero_d;
      illegal_q     <= illegal_d;
    end
  end

  assign InstrReady = !Stall && !rst;
  assign A          = issue_q.a;
  assign B          = issue_q.b;
  assign ALUControl = issue_q.op;
  assign IssueValid = issue_valid_q;
  assign ZeroFlag   = zero_q;
  assign IllegalOp  = illegal_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch with a behavioural ALU closing the writeback loop.
module tb_alu_operand_fetch;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              InstrValid;
  logic              InstrReady;
  logic [OP_W-1:0]   Op;
  logic [REG_AW-1:0] Rd, Rs1, Rs2;
  logic              UseImm;
  logic [IMM_W-1:0]  Imm;
  logic              Stall;
  logic [DATA_W-1:0] A, B;
  logic [OP_W-1:0]   ALUControl;
  logic              IssueValid;
  logic [DATA_W-1:0] WbResult;
  logic              WbZero;
  logic              ZeroFlag;
  logic              IllegalOp;
  logic [REG_AW-1:0] DbgAddr;
  logic [DATA_W-1:0] DbgData;

  int n_total = 0;
  int n_pass  = 0;

  alu_operand_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Op         (Op),
    .Rd         (Rd),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .UseImm     (UseImm),
    .Imm        (Imm),
    .Stall      (Stall),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .IssueValid (IssueValid),
    .WbResult   (WbResult),
    .WbZero     (WbZero),
    .ZeroFlag   (ZeroFlag),
    .IllegalOp  (IllegalOp),
    .DbgAddr    (DbgAddr),
    .DbgData    (DbgData)
  );

  always #10 clk = ~clk;

  // Reference 32-bit ALU feeding WbResult/WbZero.
  always_comb begin
    case (ALUControl)
      OP_ADD:  WbResult = A + B;
      OP_AND:  WbResult = A & B;
      OP_OR:   WbResult = A | B;
      OP_XOR:  WbResult = A ^ B;
      default: WbResult = '0;
    endcase
    WbZero = (WbResult == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_reg(input string tag, input int r, input logic [DATA_W-1:0] exp);
    DbgAddr = REG_AW'(r);
    #1;
    check(tag, DbgData, exp);
  endtask

  task automatic drive(input logic v, input logic [OP_W-1:0] op, input int rd, input int rs1,
                       input int rs2, input logic ui, input logic [IMM_W-1:0] imm);
    InstrValid = v;
    Op         = op;
    Rd         = REG_AW'(rd);
    Rs1        = REG_AW'(rs1);
    Rs2        = REG_AW'(rs2);
    UseImm     = ui;
    Imm        = imm;
  endtask

  task automatic idle();
    drive(1'b0, OP_ADD, 0, 0, 0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; DbgAddr = '0;
    idle();
    tick();
    rst = 1'b0;

    // Reset mid-stream discards the in-flight op.
    drive(1'b1, OP_ADD, 5, 0, 0, 1'b1, 8'h03);
    tick();
    check("pre_rst_issue_valid", 32'(IssueValid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_instr_ready", 32'(InstrReady), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_issue_valid", 32'(IssueValid), 32'd0);
    check("rst_illegal", 32'(IllegalOp), 32'd0);
    check("rst_instr_ready", 32'(InstrReady), 32'd1);
    for (int r = 0; r < 8; r++) check_reg("rst_reg", r, 32'd0);

    // Back-to-back dependency through forwarding.
    drive(1'b1, OP_ADD, 1, 0, 0, 1'b1, 8'd5);
    tick();
    check("fwd1_A", A, 32'd0);
    check("fwd1_B", B, 32'd5);
    drive(1'b1, OP_ADD, 2, 1, 0, 1'b1, 8'd7);
    tick();
    check("fwd2_A", A, 32'd5);
    check("fwd2_B", B, 32'd7);
    idle();
    tick();
    check_reg("fwd_r1", 1, 32'd5);
    check_reg("fwd_r2", 2, 32'd12);
    check("fwd_zero", 32'(ZeroFlag), 32'd0);

    // Build r1 = 0xFFFF_FFFF by doubling and or-ing in 0xFF.
    drive(1'b1, OP_ADD, 1, 0, 0, 1'b1, 8'hFF);
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 8; d++) begin
        drive(1'b1, OP_ADD, 1, 1, 1, 1'b0, 8'h00);
        tick();
      end
      drive(1'b1, OP_OR, 1, 1, 0, 1'b1, 8'hFF);
      tick();
    end
    idle();
    tick();
    check_reg("build_r1", 1, 32'hFFFF_FFFF);

    // Wrap-around to zero, then xor with itself.
    drive(1'b1, OP_ADD, 3, 1, 0, 1'b1, 8'd1);
    tick();
    check("wrap_A", A, 32'hFFFF_FFFF);
    drive(1'b1, OP_XOR, 4, 3, 3, 1'b0, 8'h00);
    tick();
    check("wrap_zero", 32'(ZeroFlag), 32'd1);
    check("xor_A_fwd", A, 32'd0);
    idle();
    tick();
    check_reg("wrap_r3", 3, 32'd0);
    check_reg("xor_r4", 4, 32'd0);
    check("xor_zero", 32'(ZeroFlag), 32'd1);

    // Stall holds the issued op and blocks new acceptance.
    drive(1'b1, OP_OR, 5, 0, 0, 1'b1, 8'h33);
    tick();
    Stall = 1'b1;
    drive(1'b1, OP_ADD, 6, 0, 0, 1'b1, 8'h44);
    #1;
    check("stall_ready", 32'(InstrReady), 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_A", A, 32'd0);
      check("stall_B", B, 32'h33);
      check("stall_ctl", 32'(ALUControl), 32'(OP_OR));
      check("stall_valid", 32'(IssueValid), 32'd1);
      check("stall_zero", 32'(ZeroFlag), 32'd1);
      check_reg("stall_r5", 5, 32'd0);
    end
    Stall = 1'b0;
    idle();
    tick();
    check("unstall_valid", 32'(IssueValid), 32'd0);
    check("unstall_zero", 32'(ZeroFlag), 32'd0);
    check_reg("unstall_r5", 5, 32'h33);
    check_reg("unstall_r6", 6, 32'd0);

    // Illegal op: sticky flag, bubble, no write; next legal op issues.
    drive(1'b1, 3'b101, 6, 1, 0, 1'b1, 8'h11);
    tick();
    check("ill_flag", 32'(IllegalOp), 32'd1);
    check("ill_valid", 32'(IssueValid), 32'd0);
    check("ill_ctl_hold", 32'(ALUControl), 32'(OP_OR));
    drive(1'b1, OP_XOR, 6, 1, 0, 1'b1, 8'h0F);
    tick();
    check("post_ill_valid", 32'(IssueValid), 32'd1);
    check("post_ill_ctl", 32'(ALUControl), 32'(OP_XOR));
    check("post_ill_A", A, 32'hFFFF_FFFF);
    check_reg("ill_no_write", 6, 32'd0);
    idle();
    tick();
    check_reg("post_ill_r6", 6, 32'hFFFF_FFF0);
    check("ill_sticky", 32'(IllegalOp), 32'd1);

    // Writes to r0 are dropped and never forwarded.
    drive(1'b1, OP_ADD, 0, 0, 0, 1'b1, 8'd9);
    tick();
    check("r0_B", B, 32'd9);
    drive(1'b1, OP_ADD, 2, 0, 0, 1'b1, 8'd1);
    tick();
    check("r0_no_fwd_A", A, 32'd0);
    check("r0_zero", 32'(ZeroFlag), 32'd0);
    idle();
    tick();
    check_reg("r0_dbg", 0, 32'd0);
    check_reg("r0_r2", 2, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
